stopwatch_ctrl: RTL and testbench

- Run/stop/lap/clear controller for the stopwatch's cascaded 8421 BCD counter chain (centiseconds, seconds, minutes).
- Takes two raw push-buttons, debounces them, and edge-detects them.
- Sequences the chain via its carry-in enable and a synchronous clear pulse.
- Drives the display-hold (lap freeze) control and saturates the stopwatch at its maximum count.

---
 rtl/stopwatch_ctrl.sv | 175 +++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/stop/lap/clear controller: debounces two push-buttons and
// sequences the BCD counter chain (carry-in, clear, lap latch, saturation).

module stopwatch_ctrl_db #(
    parameter logic [15:0] DB_N = 16'd50000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic press
);

    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic        stable_q, stable_d;
    logic        stable_dly_q, stable_dly_d;
    logic        press_q, press_d;
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d      = btn_raw;
        sync2_d      = sync1_q;
        stable_d     = stable_q;
        cnt_d        = '0;
        stable_dly_d = stable_q;
        // Pulse is registered one cycle after the stable level rises.
        press_d      = stable_q & ~stable_dly_q;
        if (sync2_q != stable_q) begin
            if (cnt_q == DB_N - 16'd1) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            press_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
            press_q      <= press_d;
            cnt_q        <= cnt_d;
        end
    end

    assign press = press_q;

endmodule

module stopwatch_ctrl #(
    parameter logic [15:0] DB_N = 16'd50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       btn_ss_raw,
    input  logic       btn_lc_raw,
    input  logic       cnt_max,
    output logic       cnt_ci,
    output logic       cnt_clr,
    output logic       lap_load,
    output logic       disp_hold,
    output logic [1:0] state
);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_LAP  = 2'b10;
    localparam logic [1:0] S_STOP = 2'b11;

    logic       ss_p, lc_p, sat;
    logic [1:0] state_q, state_d;
    logic       cnt_clr_q, cnt_clr_d;
    logic       lap_load_q, lap_load_d;
    logic       disp_hold_q, disp_hold_d;

    stopwatch_ctrl_db #(.DB_N(DB_N)) u_db_ss (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_ss_raw),
        .press   (ss_p)
    );

    stopwatch_ctrl_db #(.DB_N(DB_N)) u_db_lc (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_lc_raw),
        .press   (lc_p)
    );

    assign sat = tick & cnt_max;

    // Start/stop is checked first, so a simultaneous lap/clear press is dropped.
    always_comb begin
        state_d     = state_q;
        cnt_clr_d   = 1'b0;
        lap_load_d  = 1'b0;
        disp_hold_d = disp_hold_q;
        case (state_q)
            S_IDLE: begin
                if (ss_p) begin
                    state_d = S_RUN;
                end else if (lc_p) begin
                    cnt_clr_d = 1'b1;
                end
            end
            S_RUN: begin
                if (ss_p) begin
                    state_d = S_STOP;
                end else if (lc_p) begin
                    state_d     = S_LAP;
                    lap_load_d  = 1'b1;
                    disp_hold_d = 1'b1;
                end else if (sat) begin
                    state_d = S_STOP;
                end
            end
            S_LAP: begin
                if (ss_p) begin
                    state_d = S_STOP;
                end else if (lc_p) begin
                    state_d     = S_RUN;
                    disp_hold_d = 1'b0;
                end else if (sat) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (ss_p) begin
                    state_d     = S_RUN;
                    disp_hold_d = 1'b0;
                end else if (lc_p) begin
                    state_d     = S_IDLE;
                    cnt_clr_d   = 1'b1;
                    disp_hold_d = 1'b0;
                end
            end
            default: begin
                state_d     = S_IDLE;
                disp_hold_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_clr_q   <= 1'b0;
            lap_load_q  <= 1'b0;
            disp_hold_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_clr_q   <= cnt_clr_d;
            lap_load_q  <= lap_load_d;
            disp_hold_q <= disp_hold_d;
        end
    end

    // Uses the pre-transition state, so a tick on the edge leaving RUN still counts.
    assign cnt_ci    = tick & ((state_q == S_RUN) | (state_q == S_LAP)) & ~cnt_max;
    assign cnt_clr   = cnt_clr_q;
    assign lap_load  = lap_load_q;
    assign disp_hold = disp_hold_q;
    assign state     = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Randomized bench for stopwatch_ctrl against a cycle-level behavioural model
// of the button debouncing and the run/lap/stop/clear rules.

module tb_stopwatch_ctrl;

    localparam logic [15:0] DBN = 16'd4;
    localparam int IDLE = 0;
    localparam int RUN  = 1;
    localparam int LAP  = 2;
    localparam int STOP = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       btn_ss_raw = 1'b0;
    logic       btn_lc_raw = 1'b0;
    logic       cnt_max = 1'b0;
    logic       cnt_ci, cnt_clr, lap_load, disp_hold;
    logic [1:0] state;

    always #5 clk = ~clk;

    stopwatch_ctrl #(.DB_N(DBN)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .btn_ss_raw (btn_ss_raw),
        .btn_lc_raw (btn_lc_raw),
        .cnt_max    (cnt_max),
        .cnt_ci     (cnt_ci),
        .cnt_clr    (cnt_clr),
        .lap_load   (lap_load),
        .disp_hold  (disp_hold),
        .state      (state)
    );

    int unsigned total = 0;
    int unsigned bad   = 0;
    bit          chk_en = 1'b0;

    // Reference model: button raw history, stable level, run of differing samples.
    bit          m_d1[2], m_d2[2], m_stable[2], m_rise[2], m_press[2];
    int unsigned m_run[2];
    int          m_st;
    bit          m_clr, m_lap, m_hold;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic btn_step(input int b, input bit raw);
        bit synced;
        synced   = m_d2[b];
        m_d2[b]  = m_d1[b];
        m_d1[b]  = raw;
        m_press[b] = m_rise[b];
        m_rise[b]  = 1'b0;
        if (synced != m_stable[b]) begin
            m_run[b]++;
            if (m_run[b] == int'(DBN)) begin
                m_stable[b] = synced;
                m_run[b]    = 0;
                m_rise[b]   = synced;
            end
        end else begin
            m_run[b] = 0;
        end
    endtask

    task automatic model_edge();
        bit ss, lc, sat;
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                m_d1[b] = 0; m_d2[b] = 0; m_stable[b] = 0;
                m_rise[b] = 0; m_press[b] = 0; m_run[b] = 0;
            end
            m_st = IDLE; m_clr = 0; m_lap = 0; m_hold = 0;
        end else begin
            ss  = m_press[0];
            lc  = m_press[1];
            sat = tick && cnt_max;
            m_clr = 0;
            m_lap = 0;
            if (ss) begin
                if (m_st == IDLE)      m_st = RUN;
                else if (m_st == STOP) begin m_st = RUN; m_hold = 0; end
                else                   m_st = STOP;
            end else if (lc) begin
                if (m_st == IDLE)      m_clr = 1;
                else if (m_st == RUN)  begin m_st = LAP; m_lap = 1; m_hold = 1; end
                else if (m_st == LAP)  begin m_st = RUN; m_hold = 0; end
                else                   begin m_st = IDLE; m_clr = 1; m_hold = 0; end
            end else if (sat && (m_st == RUN || m_st == LAP)) begin
                m_st = STOP;
            end
            btn_step(0, btn_ss_raw);
            btn_step(1, btn_lc_raw);
        end
    endtask

    task automatic cycle(input bit rst, input bit t, input bit ss, input bit lc, input bit mx);
        bit exp_ci;
        @(negedge clk);
        reset = rst; tick = t; btn_ss_raw = ss; btn_lc_raw = lc; cnt_max = mx;
        #1;
        if (chk_en) begin
            exp_ci = t && !mx && (m_st == RUN || m_st == LAP);
            check_val("state", 32'(state), 32'(m_st));
            check_val("disp_hold", 32'(disp_hold), 32'(m_hold));
            check_val("lap_load", 32'(lap_load), 32'(m_lap));
            check_val("cnt_clr", 32'(cnt_clr), 32'(m_clr));
            check_val("cnt_ci", 32'(cnt_ci), 32'(exp_ci));
            check_val("clr_and_lap", 32'(cnt_clr & lap_load), 32'd0);
        end
        @(posedge clk);
        model_edge();
        chk_en = 1'b1;
    endtask

    task automatic hold(input int n, input bit ss, input bit lc, input bit mx);
        for (int i = 0; i < n; i++) cycle(1'b0, (i % 3) == 0, ss, lc, mx);
    endtask

    initial begin
        int unsigned ss_len, lc_len, mx_len;
        bit          ss_lv, lc_lv, mx_lv;

        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        // start
        hold(10, 1, 0, 0);
        hold(6, 0, 0, 0);
        // short lap glitch, then a clean lap and a second lap
        hold(3, 0, 1, 0);
        hold(8, 0, 0, 0);
        hold(8, 0, 1, 0);
        hold(8, 0, 0, 0);
        hold(8, 0, 1, 0);
        hold(8, 0, 0, 0);
        // stop, idle ticks, clear
        hold(8, 1, 0, 0);
        hold(15, 0, 0, 0);
        hold(8, 0, 1, 0);
        hold(8, 0, 0, 0);
        // run into saturation
        hold(8, 1, 0, 0);
        hold(6, 0, 0, 0);
        hold(4, 0, 0, 1);
        hold(6, 0, 0, 0);
        // back to IDLE, then both buttons together
        hold(8, 0, 1, 0);
        hold(8, 0, 0, 0);
        hold(8, 1, 1, 0);
        hold(8, 0, 0, 0);
        // lap then reset
        hold(8, 0, 1, 0);
        hold(8, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);
        hold(4, 0, 0, 0);

        ss_len = 0; lc_len = 0; mx_len = 0;
        ss_lv = 0; lc_lv = 0; mx_lv = 0;
        for (int c = 0; c < 4000; c++) begin
            if (ss_len == 0) begin ss_lv = $urandom_range(0, 1) == 1; ss_len = $urandom_range(1, 12); end
            if (lc_len == 0) begin lc_lv = $urandom_range(0, 1) == 1; lc_len = $urandom_range(1, 12); end
            if (mx_len == 0) begin mx_lv = $urandom_range(0, 5) == 0; mx_len = $urandom_range(1, 20); end
            ss_len--; lc_len--; mx_len--;
            cycle($urandom_range(0, 299) == 0, $urandom_range(0, 2) == 0, ss_lv, lc_lv, mx_lv);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
